unified_mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the instruction-fetch

---
 rtl/unified_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch and data ports
// of the core, sequencing each access through IDLE/ISSUE/WAIT/RESP.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_data  = d_req && !(if_req && starve_cnt_q == SC_W'(STARVE_MAX));
                    owner_d     = grant_data;
                    we_d        = grant_data && d_we;
                    mem_addr_d  = grant_data ? d_addr : if_addr;
                    mem_wdata_d = d_wdata;
                    // Only data grants that bypass a waiting fetch count toward starvation.
                    if (grant_data && if_req) begin
                        if (starve_cnt_q != SC_W'(STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = 4'd1;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (lat_cnt_q == 4'(MEM_LAT)) begin
                    if (!owner_q) begin
                        if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = (state_q == RESP) && !owner_q;
    assign d_done    = (state_q == RESP) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = (if_req && !if_done) || (d_req && !d_done);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised and directed checks of unified_mem_arbiter against a transaction-level
// model of the shared memory schedule.
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        logic [31:0] k;
        k = 32'(i);
        if (i == 32) return 64'hAAAA_BBBB_1111_2222;
        return {k * 32'h9E37_79B9, ~(k * 32'h85EB_CA6B)};
    endfunction

    // Memory environment: reads return MEM_LAT cycles after the mem_en cycle.
    logic [63:0] mem [256];
    logic [63:0] rd_pipe [MEM_LAT];
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) mem[mem_addr[10:3]] <= mem_wdata;
            rd_pipe[0] <= mem_en ? mem[mem_addr[10:3]] : {$urandom, $urandom};
            for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Transaction-level reference: one access owns the memory from its grant cycle
    // until its done cycle; the next grant may happen the cycle after done.
    logic [63:0] shadow [256];
    int          free_at  = 0;
    int          men_cyc  = -1;
    int          done_cyc = -1;
    int          starve   = 0;
    bit          g_own_d, g_we;
    logic [63:0] g_addr, g_wdata, g_rdata;
    logic [63:0] e_mem_addr = '0;
    logic [63:0] e_d_rdata  = '0;
    logic [31:0] e_if_rdata = '0;
    bit          e_men, e_ifd, e_dd;

    int          if_done_cyc = -1;
    int          d_done_cyc  = -1;
    logic [31:0] if_done_data;
    logic [63:0] d_done_data;
    int          men_seen_cyc = -1;
    logic [63:0] men_seen_addr;
    logic        men_seen_we;
    bit          done_log [$];

    initial for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    always @(negedge clk) begin
        if (cyc >= 1) begin
            e_men = (cyc == men_cyc);
            e_ifd = (cyc == done_cyc) && !g_own_d;
            e_dd  = (cyc == done_cyc) && g_own_d;
            if (cyc == done_cyc) begin
                if (!g_own_d) e_if_rdata = g_addr[2] ? g_rdata[63:32] : g_rdata[31:0];
                else if (!g_we) e_d_rdata = g_rdata;
            end
            chk("mem_en", mem_en, e_men);
            chk("if_done", if_done, e_ifd);
            chk("d_done", d_done, e_dd);
            chk("stall", stall, (if_req & ~e_ifd) | (d_req & ~e_dd));
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            if (e_men) begin
                chk("mem_we", mem_we, g_we);
                if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
            end

            if (if_done) begin if_done_cyc = cyc; if_done_data = if_rdata; done_log.push_back(1'b0); end
            if (d_done)  begin d_done_cyc = cyc;  d_done_data = d_rdata;   done_log.push_back(1'b1); end
            if (mem_en)  begin men_seen_cyc = cyc; men_seen_addr = mem_addr; men_seen_we = mem_we; end

            if (!reset) begin
                men_cyc    = -1;
                done_cyc   = -1;
                free_at    = cyc + 1;
                starve     = 0;
                e_mem_addr = '0;
                e_if_rdata = '0;
                e_d_rdata  = '0;
            end else if (cyc >= free_at && (if_req || d_req)) begin
                g_own_d = d_req && !(if_req && starve == STARVE_MAX);
                if (g_own_d && if_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
                else starve = 0;
                g_addr  = g_own_d ? d_addr : if_addr;
                g_we    = g_own_d && d_we;
                g_wdata = d_wdata;
                g_rdata = shadow[g_addr[10:3]];
                if (g_we) shadow[g_addr[10:3]] = g_wdata;
                e_mem_addr = g_addr;
                men_cyc  = cyc + 1;
                done_cyc = cyc + 2 + MEM_LAT;
                free_at  = done_cyc + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if(input int t0);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (if_done_cyc >= t0) begin ok = 1'b1; break; end
        end
        chk("wait_if_done", ok, 1'b1);
    endtask

    task automatic wait_d(input int t0);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (d_done_cyc >= t0) begin ok = 1'b1; break; end
        end
        chk("wait_d_done", ok, 1'b1);
    endtask

    function automatic logic [63:0] rnd_if_addr();
        return {$urandom, 21'h0, 8'($urandom_range(0, 15)), 1'($urandom), 2'b00};
    endfunction

    function automatic logic [63:0] rnd_d_addr();
        return {$urandom, 21'h0, 8'($urandom_range(0, 15)), 3'b000};
    endfunction

    initial begin
        int t0;
        int t1;
        bit ok;

        // Reset held with a pending fetch
        reset = 1'b0; if_req = 1'b1; if_addr = 64'h40;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        reset = 1'b1;
        t0 = cyc;
        wait_if(t0);
        chk("rst_release_fetch_lat", if_done_cyc - t0, 4);
        if_req = 1'b0;

        // Fetch of the upper half of word 0x100
        step();
        t0 = cyc; if_req = 1'b1; if_addr = 64'h104;
        wait_if(t0);
        if_req = 1'b0;
        chk("fetch_men_cyc", men_seen_cyc - t0, 1);
        chk("fetch_men_addr", men_seen_addr, 64'h104);
        chk("fetch_done_cyc", if_done_cyc - t0, 4);
        chk("fetch_rdata", if_done_data, 32'hAAAA_BBBB);

        // Store then load back-to-back
        step();
        t0 = cyc; d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h1234;
        wait_d(t0);
        chk("store_mem_we", men_seen_we, 1'b1);
        t1 = cyc; d_we = 1'b0;
        wait_d(t1);
        d_req = 1'b0;
        chk("load_mem_we", men_seen_we, 1'b0);
        chk("load_addr", men_seen_addr, 64'h200);
        chk("load_rdata", d_done_data, 64'h1234);

        // Simultaneous requests: data first, fetch next
        step();
        t0 = cyc; if_req = 1'b1; if_addr = 64'h100; d_req = 1'b1; d_addr = 64'h200;
        wait_d(t0);
        d_req = 1'b0;
        chk("both_d_done_cyc", d_done_cyc - t0, 4);
        wait_if(t0);
        if_req = 1'b0;
        chk("both_if_done_cyc", if_done_cyc - t0, 9);
        chk("both_if_rdata", if_done_data, 32'h1111_2222);

        // Anti-starvation: four data grants, then fetch, then data again
        step();
        done_log.delete();
        if_req = 1'b1; if_addr = 64'h110; d_req = 1'b1; d_addr = 64'h208;
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (done_log.size() >= 6) begin ok = 1'b1; break; end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("starve_wait", ok, 1'b1);
        if (ok) begin
            for (int i = 0; i < 4; i++) chk("starve_data_grant", done_log[i], 1'b1);
            chk("starve_fetch_forced", done_log[4], 1'b0);
            chk("starve_cleared", done_log[5], 1'b1);
        end

        // Reset pulse during WAIT aborts the access; the held request restarts
        step();
        t0 = cyc; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        wait_d(t0);
        d_req = 1'b0;
        chk("abort_done_cyc", d_done_cyc - t0, 7);
        chk("abort_rdata", d_done_data, init_word(32'h60));

        // Randomised traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            step();
            if (if_req) begin
                if (if_done_cyc == cyc - 1) begin
                    if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                    else if_addr = rnd_if_addr();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = rnd_if_addr();
            end
            if (d_req) begin
                if (d_done_cyc == cyc - 1) begin
                    if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                    else begin
                        d_we = 1'($urandom); d_addr = rnd_d_addr(); d_wdata = {$urandom, $urandom};
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = rnd_d_addr(); d_wdata = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
